// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel fractional clock-enable generator with a
// PLL-lock qualified reset sequencer.
//
// Ports:
//   clk        system clock (PLL output)
//   rst_n      synchronous active-low reset
//   locked     PLL lock, asynchronous to clk (synchronised here, two flops)
//   inc_a      rate set A increments, channel i at [i*ACC_W +: ACC_W]
//   inc_b      rate set B increments, same packing
//   mode_sel   per-channel requested set (0=A, 1=B)
//   sys_rst_n  registered active-low reset for downstream logic
//   ce         per-channel single-cycle clock enable
//   mode_act   per-channel rate set currently applied
//
// Each channel pulses ce at an average rate of inc_act/2^ACC_W per cycle.
// Rate-set switches land only on a carry, so the phase residue carries over
// and no period is cut short or doubled.

module clk_enable_lane #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,      // sys_rst_n as currently driven
  input  logic             run_nxt,  // value sys_rst_n takes at this edge
  input  logic [ACC_W-1:0] inc_a,
  input  logic [ACC_W-1:0] inc_b,
  input  logic             mode_sel,
  output logic             ce,
  output logic             mode_act
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_act;
  logic [ACC_W-1:0] inc_sel;
  logic [ACC_W:0]   sum;

  always_comb begin
    inc_sel = mode_sel ? inc_b : inc_a;
    sum     = {1'b0, acc} + {1'b0, inc_act};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      ce       <= 1'b0;
      inc_act  <= inc_a;
      mode_act <= 1'b0;
    end else if (!run) begin
      // Held: keep phase at zero and track the requested set each cycle.
      acc      <= '0;
      ce       <= 1'b0;
      inc_act  <= inc_sel;
      mode_act <= mode_sel;
    end else begin
      acc <= sum[ACC_W-1:0];
      // Masked on the edge sys_rst_n falls so ce is never high while
      // sys_rst_n is low.
      ce  <= sum[ACC_W] & run_nxt;
      // Switch only at a period boundary; a stopped channel never carries,
      // so it reloads every cycle and can restart.
      if (sum[ACC_W] || (inc_act == '0)) begin
        inc_act  <= inc_sel;
        mode_act <= mode_sel;
      end
    end
  end

endmodule

module clk_enable_gen #(
  parameter int CHANNELS   = 2,
  parameter int ACC_W      = 16,
  parameter int RESET_HOLD = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      locked,
  input  logic [CHANNELS*ACC_W-1:0] inc_a,
  input  logic [CHANNELS*ACC_W-1:0] inc_b,
  input  logic [CHANNELS-1:0]       mode_sel,
  output logic                      sys_rst_n,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       mode_act
);

  localparam int CNT_W = $clog2(RESET_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(RESET_HOLD);

  logic             s1;
  logic             locked_s;
  logic [CNT_W-1:0] cnt;
  logic             run_nxt;

  // Lock loss forces release low directly, not waiting on the counter.
  assign run_nxt = locked_s && (cnt == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      locked_s  <= 1'b0;
      cnt       <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      s1        <= locked;
      locked_s  <= s1;
      sys_rst_n <= run_nxt;
      if (!locked_s)
        cnt <= '0;
      else if (cnt != HOLD)
        cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_lane
    clk_enable_lane #(.ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (sys_rst_n),
      .run_nxt  (run_nxt),
      .inc_a    (inc_a[i*ACC_W +: ACC_W]),
      .inc_b    (inc_b[i*ACC_W +: ACC_W]),
      .mode_sel (mode_sel[i]),
      .ce       (ce[i]),
      .mode_act (mode_act[i])
    );
  end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
Multi-channel fractional clock-enable generator and reset sequencer for the system clock domain. It runs on the PLL system clock and qualifies reset release on a synchronised PLL lock. Each channel produces single-cycle enable pulses at a programmable average rate of f_clk*inc/2^ACC_W. Each channel switches between two rate sets (e.g. 4.77 MHz normal / turbo) without runt or doubled pulses. Downstream CPU, PIT and bus logic use the enables instead of extra PLL outputs.

Parameters:
CHANNELS, 2, number of independent enable channels (1..8)
ACC_W, 16, phase accumulator width; increment resolution 2^-ACC_W
RESET_HOLD, 1024, cycles lock must be stable before sys_rst_n releases (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
locked  in  1  PLL lock, asynchronous to clk
inc_a  in  CHANNELS*ACC_W  rate set A increments, channel i at [i*ACC_W +: ACC_W]
inc_b  in  CHANNELS*ACC_W  rate set B increments, same packing
mode_sel  in  CHANNELS  per-channel requested set: 0=A, 1=B
sys_rst_n  out  1  active-low reset for downstream logic
ce  out  CHANNELS  per-channel single-cycle clock enable
mode_act  out  CHANNELS  set currently applied per channel

Behaviour:
- Reset is synchronous and active-low, on the single clock clk.
- Reset values: sys_rst_n=0, ce=0, mode_act=0, all accumulators=0, hold counter=0, sync flops=0, active increments loaded from inc_a.
- Lock synchroniser: two flops, locked -> s1 -> locked_s. No other logic samples locked.
- Hold counter behaviour:
  - While locked_s=0: counter=0, sys_rst_n=0.
  - While locked_s=1: counter increments, saturating at RESET_HOLD.
  - sys_rst_n <= (counter==RESET_HOLD), registered.
  - Locked rising at cycle 0 gives sys_rst_n=1 at cycle RESET_HOLD+3.
- Lock loss: locked falling drives sys_rst_n=0 within 3 cycles, and the counter restarts from 0. Lock glitches shorter than 1 cycle may be missed; that is acceptable.
- While sys_rst_n=0: accumulators are held at 0, ce=0, and the active increment and mode_act reload from mode_sel every cycle.
- Per channel, while sys_rst_n=1:
  - Each cycle {carry, acc} = acc + inc_act, computed at ACC_W+1 bits.
  - ce[i] <= carry, so ce is registered, 1 cycle after the wrapping add.
  - Average rate is exactly inc_act/2^ACC_W pulses per cycle.
  - ce is never high 2 consecutive cycles unless inc_act >= 2^(ACC_W-1)+1.
- Mode switch:
  - inc_act and mode_act update only on a cycle where carry=1, taking the value selected by mode_sel that cycle.
  - The accumulator is not cleared on a switch; the residual phase carries over, so no period is truncated or doubled.
  - mode_sel changes with no following carry have no effect until the next carry.
- inc_act==0 (stopped channel): no carry ever occurs, so inc_act/mode_act reload from the selected set every cycle. A stopped channel restarts on the cycle after mode_sel selects a non-zero set.
- inc_a/inc_b value changes: picked up at the next carry, or every cycle if inc_act==0.
- Maximum increment 2^ACC_W-1; full rate (ce every cycle) is not supported.
- rst_n asserted mid-operation: all state returns to reset values on the next edge; ce drops the same edge.

Test Plan:
- Lock sequencing: RESET_HOLD=16, locked rises at cycle 10 -> sys_rst_n=1 at cycle 29; ce stays 0 before then.
- Lock loss: locked falls at cycle 100 -> sys_rst_n=0 by cycle 103, ce=0. Locked re-rises at 120 -> sys_rst_n=1 at 139.
- Rate accuracy: ACC_W=16, inc_a=0x4000 -> ce exactly every 4th cycle. inc_a=0x30D9 -> 12505 pulses in 65536 cycles, and the gap between consecutive pulses is always 5 or 6 cycles.
- Glitch-free switch: inc_a=0x4000, inc_b=0x8000, mode_sel toggled mid-period -> remaining gap is still 4 cycles, then period 2. mode_act changes the cycle after the wrap, and there is never a gap <2 or a doubled pulse.
- Stopped channel: inc_a=0, inc_b=0x8000. Channel silent for 1000 cycles; mode_sel=1 at cycle N -> first ce at N+3, then every 2 cycles. Other channel unaffected.
- Mid-run reset: rst_n low for 1 cycle while ce pulsing -> ce=0, sys_rst_n=0 next edge, full RESET_HOLD sequence repeats.
